// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder: multi-cycle WIDTH-bit adder built around a single shared
// CHUNK-bit carry-lookahead adder. Operands are added one chunk per clock,
// least-significant chunk first. The carry between chunks is held in a
// register and is rebuilt from the chunk's group propagate/generate.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high
//   io_in_valid   operand request
//   io_in_ready   operands accepted when valid & ready at a rising edge
//   io_in_a/b     WIDTH-bit operands
//   io_in_cin     carry-in
//   io_out_valid  result available (held until io_out_ready)
//   io_out_ready  consumer accepts result
//   io_out_sum    (a + b + cin) mod 2^WIDTH
//   io_out_cout   carry out of bit WIDTH-1
//   io_busy       high while a transaction is in progress (RUN or DONE)
// ---------------------------------------------------------------------------

// Combinational W-bit carry-lookahead adder with group P/G outputs.
// io_cpg_p is the AND of the per-bit OR-propagates, io_cpg_g the group
// generate, so the chunk carry-out is io_cpg_g | (io_cpg_p & io_cpg_carry).
module cla_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] io_a,
    input  logic [W-1:0] io_b,
    input  logic         io_cpg_carry,
    output logic [W-1:0] io_s,
    output logic         io_cpg_p,
    output logic         io_cpg_g
);
    logic [W-1:0] bit_g;
    logic [W-1:0] bit_p;

    always_comb begin
        logic cc;
        logic rp;
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        bit_g    = io_a & io_b;
        bit_p    = io_a | io_b;
        io_s     = '0;
        cc       = 1'b0;
        rp       = 1'b1;
        // Each bit's carry is a flat sum-of-products over the lower bits
        // rather than a ripple from its neighbour.
        for (int i = 0; i < W; i++) begin
            cc = 1'b0;
            rp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (bit_g[j] & rp);
                rp = rp & bit_p[j];
            end
            io_s[i] = io_a[i] ^ io_b[i] ^ (cc | (rp & io_cpg_carry));
        end
        cc = 1'b0;
        rp = 1'b1;
        for (int j = W - 1; j >= 0; j--) begin
            cc = cc | (bit_g[j] & rp);
            rp = rp & bit_p[j];
        end
        io_cpg_g = cc;
        io_cpg_p = rp;
    end
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_cin,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_cout,
    output logic             io_busy
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int R      = WIDTH % CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry_reg;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  sum_reg;
    logic              cout_reg;

    logic [CHUNK-1:0]  add_a;
    logic [CHUNK-1:0]  add_b;
    logic              add_cin;
    logic [CHUNK-1:0]  add_s;
    logic              add_p;
    logic              add_g;
    logic              chunk_cout;
    logic              last_chunk;
    logic [WIDTH-1:0]  sum_next;

    cla_chunk #(.W(CHUNK)) u_cla (
        .io_a         (add_a),
        .io_b         (add_b),
        .io_cpg_carry (add_cin),
        .io_s         (add_s),
        .io_cpg_p     (add_p),
        .io_cpg_g     (add_g)
    );

    // Chunk select and sum merge. Operand bits beyond WIDTH are left at the
    // zero default, which is the zero padding of the last chunk. Outside RUN
    // the adder inputs stay at zero so the tree does not toggle.
    always_comb begin
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        sum_next = sum_reg;
        if (state == RUN) begin
            add_cin = carry_reg;
            for (int n = 0; n < WIDTH; n++) begin
                if (n / CHUNK == int'(idx)) begin
                    add_a[n % CHUNK] = a_reg[n];
                    add_b[n % CHUNK] = b_reg[n];
                end
            end
        end
        for (int n = 0; n < WIDTH; n++) begin
            if (n / CHUNK == int'(idx)) begin
                sum_next[n] = add_s[n % CHUNK];
            end
        end
    end

    assign chunk_cout = add_g | (add_p & carry_reg);
    assign last_chunk = (idx == IDXW'(NCHUNK - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (io_in_valid)  state_next = RUN;
            RUN:     if (last_chunk)   state_next = DONE;
            DONE:    if (io_out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    // NOTE: a_reg/b_reg carry no reset; they are always loaded on
    // acceptance before the datapath reads them.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        a_reg     <= io_in_a;
                        b_reg     <= io_in_b;
                        carry_reg <= io_in_cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= chunk_cout;
                    if (last_chunk) begin
                        // With a partial last chunk the padded sum bit R is
                        // the true carry out of bit WIDTH-1.
                        cout_reg <= (R == 0) ? chunk_cout : add_s[R];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are forced low for the whole reset cycle.
    assign io_in_ready  = !reset && (state == IDLE);
    assign io_out_valid = !reset && (state == DONE);
    assign io_busy      = !reset && ((state == RUN) || (state == DONE));
    assign io_out_sum   = sum_reg;
    assign io_out_cout  = cout_reg;
endmodule

// File: tb/tb_cla_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_adder: directed + throttled-random checks of cla_seq_adder in
// two configurations sharing one clock and reset: WIDTH=16/CHUNK=4 and
// WIDTH=10/CHUNK=4 (partial last chunk).
// ---------------------------------------------------------------------------
module tb_cla_seq_adder;
    logic        clock;
    logic        reset;

    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [15:0] in_a, in_b, out_sum;

    logic        in_valid_w, in_ready_w, in_cin_w, out_valid_w, out_ready_w, out_cout_w, busy_w;
    logic [9:0]  in_a_w, in_b_w, out_sum_w;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec16_t;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic       cin;
        logic [9:0] sum;
        logic       cout;
    } vec10_t;

    cla_seq_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (in_ready),
        .io_in_a      (in_a),
        .io_in_b      (in_b),
        .io_in_cin    (in_cin),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_out_sum   (out_sum),
        .io_out_cout  (out_cout),
        .io_busy      (busy)
    );

    cla_seq_adder #(.WIDTH(10), .CHUNK(4)) dut10 (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (in_valid_w),
        .io_in_ready  (in_ready_w),
        .io_in_a      (in_a_w),
        .io_in_b      (in_b_w),
        .io_in_cin    (in_cin_w),
        .io_out_valid (out_valid_w),
        .io_out_ready (out_ready_w),
        .io_out_sum   (out_sum_w),
        .io_out_cout  (out_cout_w),
        .io_busy      (busy_w)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one 16-bit op starting at a negedge with the DUT idle; hold the
    // result for 'stall' extra cycles before accepting it. Ends at a negedge.
    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input int stall, input logic [15:0] exp_sum, input logic exp_cout);
        int lat;
        int busy_cnt;
        bit got;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        out_ready = (stall == 0);
        #1 check("w16 in_ready before accept", in_ready, 1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
        lat = 0; busy_cnt = 0; got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (busy) busy_cnt++;
            if (out_valid) begin
                got = 1;
                break;
            end
            @(posedge clock);
            lat++;
        end
        check("w16 out_valid seen", got, 1);
        if (!got) return;
        check("w16 latency", lat, 4);
        check("w16 busy cycles", busy_cnt, 5);
        for (int s = 0; s < stall; s++) begin
            @(posedge clock);
            @(negedge clock);
            check("w16 valid held", out_valid, 1);
            check("w16 sum held", out_sum, exp_sum);
        end
        out_ready = 1'b1;
        check("w16 sum", out_sum, exp_sum);
        check("w16 cout", out_cout, exp_cout);
        @(posedge clock);
        @(negedge clock);
        check("w16 valid pulse ends", out_valid, 0);
        check("w16 idle after handshake", {busy, in_ready}, 2'b01);
    endtask

    task automatic do_op10(input logic [9:0] a, input logic [9:0] b, input logic cin,
                           input logic [9:0] exp_sum, input logic exp_cout);
        int lat;
        bit got;
        in_a_w = a; in_b_w = b; in_cin_w = cin; in_valid_w = 1'b1; out_ready_w = 1'b1;
        #1 check("w10 in_ready before accept", in_ready_w, 1);
        @(posedge clock);
        #1 in_valid_w = 1'b0;
        in_a_w = 10'($urandom); in_b_w = 10'($urandom);
        lat = 0; got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (out_valid_w) begin
                got = 1;
                break;
            end
            @(posedge clock);
            lat++;
        end
        check("w10 out_valid seen", got, 1);
        if (!got) return;
        check("w10 latency", lat, 3);
        check("w10 sum", out_sum_w, exp_sum);
        check("w10 cout", out_cout_w, exp_cout);
        @(posedge clock);
        @(negedge clock);
        check("w10 valid pulse ends", out_valid_w, 0);
    endtask

    task automatic wait_valid16(output bit got);
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        check("w16 out_valid seen (seq)", got, 1);
    endtask

    initial begin
        vec16_t v16[10];
        vec10_t v10[5];
        bit got;
        logic [16:0] ref17;
        logic [10:0] ref11;
        logic [15:0] ra, rb;
        logic [9:0]  wa, wb;
        logic        rc;

        v16[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
        v16[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        v16[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        v16[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        v16[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        v16[5] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
        v16[6] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
        v16[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        v16[8] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1};
        v16[9] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};

        v10[0] = '{10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1};
        v10[1] = '{10'h200, 10'h100, 1'b0, 10'h300, 1'b0};
        v10[2] = '{10'h2AA, 10'h155, 1'b1, 10'h000, 1'b1};
        v10[3] = '{10'h3FF, 10'h3FF, 1'b1, 10'h3FF, 1'b1};
        v10[4] = '{10'h123, 10'h0AB, 1'b0, 10'h1CE, 1'b0};

        reset = 1'b1;
        in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
        in_valid_w = 0; in_a_w = 0; in_b_w = 0; in_cin_w = 0; out_ready_w = 0;

        @(negedge clock);
        check("reset in_ready gated", in_ready, 0);
        check("reset busy gated", busy, 0);
        check("reset out_valid gated", out_valid, 0);
        reset = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1);
        check("post-reset sum", out_sum, 16'h0000);
        check("post-reset cout", out_cout, 0);
        check("post-reset w10 in_ready", in_ready_w, 1);
        @(negedge clock);

        for (int i = 0; i < 10; i++)
            do_op16(v16[i].a, v16[i].b, v16[i].cin, 0, v16[i].sum, v16[i].cout);
        for (int i = 0; i < 5; i++)
            do_op10(v10[i].a, v10[i].b, v10[i].cin, v10[i].sum, v10[i].cout);

        // Backpressure: result held, new operands presented but not accepted.
        in_a = 16'h00FF; in_b = 16'h0001; in_cin = 0; in_valid = 1; out_ready = 0;
        @(posedge clock);
        #1 in_a = 16'h1111; in_b = 16'h2222;
        wait_valid16(got);
        for (int s = 0; s < 5; s++) begin
            check("bp valid held", out_valid, 1);
            check("bp sum held", out_sum, 16'h0100);
            check("bp in_ready low", in_ready, 0);
            @(posedge clock);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp idle after release", {out_valid, in_ready}, 2'b01);
        @(posedge clock);
        #1 in_valid = 0;
        @(negedge clock);
        check("bp second accepted", busy, 1);
        wait_valid16(got);
        check("bp second sum", out_sum, 16'h3333);
        check("bp second cout", out_cout, 0);
        @(posedge clock);
        @(negedge clock);

        // Reset after two RUN edges aborts the transaction.
        in_a = 16'h1234; in_b = 16'h1111; in_cin = 0; in_valid = 1; out_ready = 1;
        @(posedge clock);
        #1 in_valid = 0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1 check("mid-run reset gates in_ready", in_ready, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 1);
        check("abort sum cleared", out_sum, 16'h0000);
        @(negedge clock);
        do_op16(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0);

        // Throttled random traffic against an arithmetic reference.
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            ref17 = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
            repeat ($urandom_range(0, 2)) @(negedge clock);
            do_op16(ra, rb, rc, int'($urandom_range(0, 3)), ref17[15:0], ref17[16]);
        end
        for (int i = 0; i < 100; i++) begin
            wa = 10'($urandom); wb = 10'($urandom); rc = 1'($urandom);
            ref11 = {1'b0, wa} + {1'b0, wb} + {10'h0, rc};
            repeat ($urandom_range(0, 2)) @(negedge clock);
            do_op10(wa, wb, rc, ref11[9:0], ref11[10]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
